// File: rtl/width_narrow_if.sv
// rtl/width_narrow_if.sv - rts/rtr framed stream bundle used on both sides of the downsizer
interface width_narrow_if #(
   parameter int W = 8
);
   logic         rts;
   logic         rtr;
   logic         sow;
   logic         eow;
   logic [W-1:0] data;

   modport master (output rts, output sow, output eow, output data, input rtr);
   modport slave  (input rts, input sow, input eow, input data, output rtr);
endinterface

// File: rtl/width_narrow.sv
// rtl/width_narrow.sv - stream downsizer, emits each wide word as LSB-first narrow slices
module width_narrow #(
   parameter int DATAi_W = 8,
   parameter int DATAo_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   width_narrow_if.slave    s_if,
   width_narrow_if.master   m_if,
   output logic             oerr
);

   localparam int RATIO = DATAi_W / DATAo_W;
   localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

   generate
      if ((DATAi_W % DATAo_W) != 0 || RATIO < 2) begin : g_param_check
         $error("width_narrow: DATAi_W must be a multiple of DATAo_W with ratio >= 2");
      end
   endgenerate

   typedef enum logic {
      EMPTY = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DATAi_W-1:0]   word_q, word_d;
   logic                 sow_q, sow_d;
   logic                 eow_q, eow_d;
   logic                 in_frame_q, in_frame_d;
   logic                 oerr_q, oerr_d;

   logic                 last_slice;
   logic                 rtr;
   logic                 in_xfer;
   logic                 out_xfer;
   logic [DATAi_W-1:0]   shifted;

   // A new word is taken when idle, or in the same cycle the last slice of the held word leaves
   assign last_slice = (cnt_q == LAST);
   assign rtr        = !rst && ((state_q == EMPTY) || ((state_q == SHIFT) && last_slice && m_if.rtr));
   assign in_xfer    = s_if.rts && rtr;
   assign out_xfer   = (state_q == SHIFT) && m_if.rtr;
   assign shifted    = word_q >> (int'(cnt_q) * DATAo_W);

   assign s_if.rtr   = rtr;
   assign m_if.rts   = (state_q == SHIFT);
   assign m_if.data  = (state_q == SHIFT) ? shifted[DATAo_W-1:0] : '0;
   assign m_if.sow   = (state_q == SHIFT) && sow_q && (cnt_q == '0);
   assign m_if.eow   = (state_q == SHIFT) && eow_q && last_slice;
   assign oerr       = oerr_q;

   // Next-state: slice sequencing, word capture and frame tracking
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      sow_d      = sow_q;
      eow_d      = eow_q;
      in_frame_d = in_frame_q;
      oerr_d     = oerr_q;

      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               word_d  = s_if.data;
               sow_d   = s_if.sow;
               eow_d   = s_if.eow;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (out_xfer) begin
               if (last_slice) begin
                  if (in_xfer) begin
                     word_d = s_if.data;
                     sow_d  = s_if.sow;
                     eow_d  = s_if.eow;
                     cnt_d  = '0;
                  end else begin
                     state_d = EMPTY;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = EMPTY;
      endcase

      // Framing errors are flagged but the word is still forwarded untouched
      if (in_xfer) begin
         if ((s_if.sow && in_frame_q) || (!s_if.sow && !in_frame_q)) begin
            oerr_d = 1'b1;
         end
         if (s_if.sow) begin
            in_frame_d = 1'b1;
         end
         if (s_if.eow) begin
            in_frame_d = 1'b0;
         end
      end
   end

   // State register with synchronous reset; pending slices are dropped on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         cnt_q      <= '0;
         word_q     <= '0;
         sow_q      <= 1'b0;
         eow_q      <= 1'b0;
         in_frame_q <= 1'b0;
         oerr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         sow_q      <= sow_d;
         eow_q      <= eow_d;
         in_frame_q <= in_frame_d;
         oerr_q     <= oerr_d;
      end
   end

endmodule

// File: tb/tb_width_narrow.sv
// tb/tb_width_narrow.sv - scoreboard bench for the 8->4 and 16->4 stream downsizer
module tb_width_narrow;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   width_narrow_if #(.W(8))  i8  ();
   width_narrow_if #(.W(4))  o8  ();
   width_narrow_if #(.W(16)) i16 ();
   width_narrow_if #(.W(4))  o16 ();
   logic oerr8, oerr16;

   width_narrow #(.DATAi_W(8), .DATAo_W(4)) dut (
      .clk(clk), .rst(rst), .s_if(i8.slave), .m_if(o8.master), .oerr(oerr8)
   );

   width_narrow #(.DATAi_W(16), .DATAo_W(4)) dut16 (
      .clk(clk), .rst(rst), .s_if(i16.slave), .m_if(o16.master), .oerr(oerr16)
   );

   typedef struct packed {
      logic [3:0] d;
      logic       s;
      logic       e;
   } slice_t;

   slice_t q8[$];
   slice_t q16[$];
   int     n_pass  = 0;
   int     n_total = 0;
   int     cyc     = 0;
   int     rtr_mode = 0;
   bit     m_in_frame = 1'b0;
   bit     m_oerr     = 1'b0;
   int     acc_cyc;
   logic   acc_rts;
   slice_t prev8;
   bit     held8 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Downstream ready pattern for the 8-bit instance
   initial begin
      o8.rtr  = 1'b1;
      o16.rtr = 1'b1;
      forever begin
         @(negedge clk);
         case (rtr_mode)
            0:       o8.rtr = 1'b1;
            1:       o8.rtr = !o8.rtr;
            default: o8.rtr = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor for the 8-bit instance: compares taken slices and checks holding while stalled
   initial begin
      slice_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && o8.rts) begin
            if (held8) check("hold8", {o8.data, o8.sow, o8.eow}, 32'(prev8));
            if (o8.rtr) begin
               if (q8.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_slice8: got data 0x%0h sow %0b eow %0b with nothing expected",
                           o8.data, o8.sow, o8.eow);
               end else begin
                  e = q8.pop_front();
                  check("slice8", {o8.data, o8.sow, o8.eow}, 32'(e));
               end
               held8 = 1'b0;
            end else begin
               held8 = 1'b1;
               prev8 = {o8.data, o8.sow, o8.eow};
            end
         end else begin
            held8 = 1'b0;
         end
      end
   end

   // Monitor for the 16-bit instance
   initial begin
      slice_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && o16.rts && o16.rtr) begin
            if (q16.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_slice16: got data 0x%0h with nothing expected", o16.data);
            end else begin
               e = q16.pop_front();
               check("slice16", {o16.data, o16.sow, o16.eow}, 32'(e));
            end
         end
      end
   end

   task automatic send8(input logic [7:0] w, input logic s, input logic e);
      int     t;
      bit     done;
      slice_t ex;
      logic [7:0] sh;
      @(negedge clk);
      i8.rts  = 1'b1;
      i8.data = w;
      i8.sow  = s;
      i8.eow  = e;
      t = 0;
      done = 0;
      while (!done) begin
         #1;
         if (i8.rtr) begin
            acc_cyc = cyc;
            acc_rts = o8.rts;
            for (int i = 0; i < 2; i++) begin
               sh   = w >> (4 * i);
               ex.d = sh[3:0];
               ex.s = s && (i == 0);
               ex.e = e && (i == 1);
               q8.push_back(ex);
            end
            if ((s && m_in_frame) || (!s && !m_in_frame)) m_oerr = 1'b1;
            if (s) m_in_frame = 1'b1;
            if (e) m_in_frame = 1'b0;
            @(posedge clk);
            done = 1;
         end else begin
            t++;
            if (t > 200) begin
               n_total++;
               $display("FAIL accept_timeout8: word 0x%0h not accepted within %0d cycles", w, t);
               done = 1;
            end else begin
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic idle8();
      @(negedge clk);
      i8.rts  = 1'b0;
      i8.data = 8'($urandom);
      i8.sow  = 1'($urandom);
      i8.eow  = 1'($urandom);
   endtask

   task automatic drain8();
      int t = 0;
      while (q8.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      check("drain8", q8.size(), 0);
   endtask

   initial begin
      int c0;
      int t;
      logic [15:0] w16;
      logic [15:0] sh16;
      slice_t ex;
      bit s, e;
      int len;

      rst      = 1'b1;
      i8.rts   = 1'b0; i8.sow = 1'b0; i8.eow = 1'b0; i8.data = '0;
      i16.rts  = 1'b0; i16.sow = 1'b0; i16.eow = 1'b0; i16.data = '0;

      repeat (3) @(negedge clk);
      #2;
      check("reset_rts_o",  o8.rts, 0);
      check("reset_rtr_o",  i8.rtr, 0);
      check("reset_oerr",   oerr8, 0);
      check("reset_data_o", o8.data, 0);
      check("reset_sow_eow", {o8.sow, o8.eow}, 0);
      rst = 1'b0;
      @(negedge clk);
      #2;
      check("rtr_o_after_reset", i8.rtr, 1);

      // Single-word frame, latency of one cycle
      rtr_mode = 0;
      send8(8'hA5, 1'b1, 1'b1);
      check("rts_low_at_accept", acc_rts, 0);
      idle8();
      #2;
      check("rts_one_cycle_after", o8.rts, 1);
      drain8();
      check("oerr_single", oerr8, 0);

      // Back-to-back frame at full throughput
      send8(8'h21, 1'b1, 1'b0);
      c0 = acc_cyc;
      send8(8'h43, 1'b0, 1'b0);
      check("accept_spacing1", acc_cyc - c0, 2);
      c0 = acc_cyc;
      send8(8'h65, 1'b0, 1'b1);
      check("accept_spacing2", acc_cyc - c0, 2);
      idle8();
      drain8();
      check("oerr_frame", oerr8, 0);

      // Same frame with downstream stalling every other cycle
      rtr_mode = 1;
      send8(8'h21, 1'b1, 1'b0);
      c0 = acc_cyc;
      send8(8'h43, 1'b0, 1'b0);
      check("toggle_spacing1", (acc_cyc - c0) >= 2, 1);
      c0 = acc_cyc;
      send8(8'h65, 1'b0, 1'b1);
      check("toggle_spacing2", (acc_cyc - c0) >= 2, 1);
      idle8();
      drain8();
      check("oerr_toggle", oerr8, 0);

      // Start-of-window inside an open frame
      rtr_mode = 0;
      send8(8'h11, 1'b1, 1'b0);
      send8(8'hF0, 1'b1, 1'b0);
      idle8();
      drain8();
      check("oerr_double_sow", oerr8, 32'(m_oerr));
      send8(8'h22, 1'b0, 1'b1);
      idle8();
      drain8();
      check("oerr_sticky", oerr8, 32'(m_oerr));

      // Reset between the two slices of a word
      send8(8'hA5, 1'b1, 1'b1);
      idle8();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #2;
      check("rst_mid_rts_o", o8.rts, 0);
      check("rst_mid_oerr",  oerr8, 0);
      check("rst_mid_rtr_o", i8.rtr, 0);
      check("rst_mid_leftover", q8.size(), 1);
      q8.delete();
      m_in_frame = 1'b0;
      m_oerr     = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      #2;
      check("rst_release_rtr_o", i8.rtr, 1);
      repeat (4) @(negedge clk);
      #2;
      check("rst_no_stale_slice", o8.rts, 0);

      // Random frames, random gaps, random downstream stalls, occasional bad framing
      rtr_mode = 2;
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, 4);
         for (int j = 0; j < len; j++) begin
            s = (j == 0);
            e = (j == len - 1);
            if ($urandom_range(0, 19) == 0) s = !s;
            send8(8'($urandom), s, e);
            if ($urandom_range(0, 3) == 0) idle8();
         end
      end
      idle8();
      drain8();
      check("oerr_random", oerr8, 32'(m_oerr));

      // 16-bit to 4-bit instance
      w16 = 16'h1234;
      @(negedge clk);
      i16.rts  = 1'b1;
      i16.data = w16;
      i16.sow  = 1'b1;
      i16.eow  = 1'b1;
      #1;
      check("accept16", i16.rtr, 1);
      for (int i = 0; i < 4; i++) begin
         sh16 = w16 >> (4 * i);
         ex.d = sh16[3:0];
         ex.s = (i == 0);
         ex.e = (i == 3);
         q16.push_back(ex);
      end
      @(negedge clk);
      i16.rts = 1'b0;
      t = 0;
      while (q16.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      check("drain16", q16.size(), 0);
      check("oerr16", oerr16, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
